fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_if.sv | 36 +++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard control, instruction memory and IF/ID outputs.
// FETCH_PERF_EN adds the fetchCount/stallCount performance counters.
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic [31:0] imemAddress;
  logic [31:0] imemData;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        validD;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  modport master (
    output stall, flush, pcSrc, branchTarget, imemData,
    input  imemAddress, instrD, pcD, pcPlus4D, validD, fetchCount, stallCount
  );
  modport slave (
    input  stall, flush, pcSrc, branchTarget, imemData,
    output imemAddress, instrD, pcD, pcPlus4D, validD, fetchCount, stallCount
  );
`else
  modport master (
    output stall, flush, pcSrc, branchTarget, imemData,
    input  imemAddress, instrD, pcD, pcPlus4D, validD
  );
  modport slave (
    input  stall, flush, pcSrc, branchTarget, imemData,
    output imemAddress, instrD, pcD, pcPlus4D, validD
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register plus IF/ID pipeline register.
// Define FETCH_PERF_EN to add the fetchCount/stallCount performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic    clk,
  input logic    rst,
  fetch_if.slave bus
);

  // Keep the PC word-aligned even if a misaligned reset vector is supplied.
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect wins over stall so a taken branch is never lost.
  always_comb begin
    pc_d = pc_q;
    if (bus.pcSrc) begin
      pc_d = {bus.branchTarget[31:2], 2'b00};
    end else if (!bus.stall) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (bus.flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d = bus.imemData;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= ResetPcAligned;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imemAddress = pc_q;
  assign bus.instrD      = instr_q;
  assign bus.pcD         = pcd_q;
  assign bus.pcPlus4D    = pcp4_q;
  assign bus.validD      = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (!bus.flush && !bus.stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!bus.flush && bus.stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.fetchCount = fetch_cnt_q;
  assign bus.stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reference model plus per-cycle compare and literal checks.
// Honours FETCH_PERF_EN when the counters are built in.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fetch_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (Nop)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      32'hC:   return 32'h0000_0044;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign bus.imemData = imem(bus.imemAddress);

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_fcnt, m_scnt;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = Nop; m_pcd = 32'h0; m_pcp4 = 32'h0;
    m_valid = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("imemAddress", bus.imemAddress, m_pc);
    chk("instrD", bus.instrD, m_instr);
    chk("pcD", bus.pcD, m_pcd);
    chk("pcPlus4D", bus.pcPlus4D, m_pcp4);
    chk("validD", {31'b0, bus.validD}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
    chk("fetchCount", bus.fetchCount, m_fcnt);
    chk("stallCount", bus.stallCount, m_scnt);
`endif
  end

  // Apply one cycle of hazard inputs; model advances on the same edge as the DUT.
  task automatic cycle(input logic st, input logic fl, input logic ps, input logic [31:0] bt);
    logic [31:0] n_pc, fetched;
    bus.stall = st; bus.flush = fl; bus.pcSrc = ps; bus.branchTarget = bt;
    fetched = imem(m_pc);
    n_pc = ps ? (bt & 32'hFFFF_FFFC) : (st ? m_pc : m_pc + 32'd4);
    @(posedge clk);
    if (fl) begin
      m_instr = Nop; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = fetched; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
      m_fcnt++;
    end
    if (st && !fl) m_scnt++;
    m_pc = n_pc;
    #2;
  endtask

  initial begin
    model_reset();
    bus.stall = 1'b1; bus.flush = 1'b1; bus.pcSrc = 1'b1; bus.branchTarget = 32'h100;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_instr", bus.instrD, 32'h13);
    chk("rst_valid", {31'b0, bus.validD}, 32'h0);
    rst = 1'b0;

    // Straight-line fetch from reset vector
    cycle(0, 0, 0, 0);
    chk("c1_instr", bus.instrD, 32'h11);
    chk("c1_pcD", bus.pcD, 32'h0);
    cycle(0, 0, 0, 0);
    chk("c2_instr", bus.instrD, 32'h22);
    chk("c2_pcD", bus.pcD, 32'h4);

    // Stall two cycles at PC=8
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("stall_addr", bus.imemAddress, 32'h8);
    chk("stall_instr", bus.instrD, 32'h22);
`ifdef FETCH_PERF_EN
    chk("stall_cnt", bus.stallCount, 32'd2);
`endif
    cycle(0, 0, 0, 0);
    chk("c3_instr", bus.instrD, 32'h33);
    chk("c3_pcD", bus.pcD, 32'h8);
    cycle(0, 0, 0, 0);

    // Taken branch at PC=0x10: redirect + flush
    chk("pre_br_addr", bus.imemAddress, 32'h10);
    cycle(0, 1, 1, 32'h40);
    chk("br_addr", bus.imemAddress, 32'h40);
    chk("br_instr", bus.instrD, 32'h13);
    chk("br_valid", {31'b0, bus.validD}, 32'h0);
    cycle(0, 0, 0, 0);
    chk("br_tgt_instr", bus.instrD, 32'hC0DE_0040);

    // Redirect during stall, misaligned target
    cycle(1, 0, 1, 32'h43);
    chk("rs_addr", bus.imemAddress, 32'h40);
    chk("rs_pcD", bus.pcD, 32'h40);
    cycle(0, 0, 0, 0);

    // Flush overrides stall
    cycle(1, 1, 0, 0);
    chk("fs_valid", {31'b0, bus.validD}, 32'h0);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap_addr", bus.imemAddress, 32'h0);
    chk("wrap_pcp4", bus.pcPlus4D, 32'h0);
    chk("wrap_pcD", bus.pcD, 32'hFFFF_FFFC);

    // Mixed pattern
    for (int i = 0; i < 12; i++) cycle(i % 3 == 1, i % 5 == 4, i % 4 == 3, 32'h200 + i * 8);

    // Async reset mid-stall/mid-redirect, between edges
    bus.stall = 1'b1; bus.pcSrc = 1'b1; bus.branchTarget = 32'h80;
    #1 rst = 1'b1;
    #1;
    chk("ar_addr", bus.imemAddress, 32'h0);
    chk("ar_instr", bus.instrD, 32'h13);
    chk("ar_pcD", bus.pcD, 32'h0);
    chk("ar_valid", {31'b0, bus.validD}, 32'h0);
    model_reset();
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    chk("ar_restart_instr", bus.instrD, 32'h11);
    chk("ar_restart_addr", bus.imemAddress, 32'h4);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
